// File: rtl/debounce_multi.sv
// debounce_multi: N-channel push-button conditioner.
//   Each channel synchronises its raw input, rejects bounce shorter than
//   HOLD_CYCLES consecutive samples, and produces a clean level plus
//   one-cycle press/release pulses. With REPEAT_CYCLES > 0, a held button
//   re-fires press_pulse every REPEAT_CYCLES cycles.
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   button[N_CH]  raw asynchronous inputs, 1 = pressed
//   level[N_CH]   debounced level
//   press_pulse   1-cycle pulse on accepted press and on each repeat
//   release_pulse 1-cycle pulse on accepted release
//   any_press     OR of press_pulse, registered

// debounce_ch: one channel of the conditioner (sync + 2-state filter + repeat).
// Ports: clk, rst_n, button (raw), level/press_pulse/release_pulse (registered),
//   press_d (next-cycle press_pulse, used to build a registered any_press).
module debounce_ch #(
  parameter int HOLD_CYCLES   = 25000000,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic press_d
);
  localparam int MAXC  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_M1  = (REPEAT_CYCLES > 0) ? CNT_W'(REPEAT_CYCLES - 1) : '0;

  typedef enum logic {ST_STABLE, ST_COUNT} state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state, state_d;
  logic [CNT_W-1:0]       cnt, cnt_d, rcnt, rcnt_d;
  logic                   level_d, rel_d;

  assign s = sync[SYNC_STAGES-1];

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    level_d = level;
    press_d = 1'b0;
    rel_d   = 1'b0;
    rcnt_d  = '0;
    case (state)
      ST_STABLE: begin
        cnt_d = '0;
        if (s != level) begin
          state_d = ST_COUNT;
          cnt_d   = CNT_W'(1);  // this sample is the first of HOLD_CYCLES
        end
      end
      default: begin
        if (s == level) begin
          // reverting sample: candidate dropped, count restarts from scratch
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt == HOLD_M1) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          level_d = s;
          press_d = s;
          rel_d   = ~s;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
    endcase
    // Repeat counter runs only while held and not debouncing a release;
    // the acceptance cycle itself is in ST_COUNT, so it starts from zero.
    if (REPEAT_CYCLES > 0 && level && state == ST_STABLE) begin
      if (rcnt == REP_M1) begin
        press_d = 1'b1;
        rcnt_d  = '0;
      end else begin
        rcnt_d = rcnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync          <= '0;
      state         <= ST_STABLE;
      cnt           <= '0;
      rcnt          <= '0;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync          <= {sync[SYNC_STAGES-2:0], button};
      state         <= state_d;
      cnt           <= cnt_d;
      rcnt          <= rcnt_d;
      level         <= level_d;
      press_pulse   <= press_d;
      release_pulse <= rel_d;
    end
  end
endmodule

module debounce_multi #(
  parameter int N_CH          = 4,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int SYNC_STAGES   = 2,
  parameter int REPEAT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic            any_press
);
  logic [N_CH-1:0] press_d;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .SYNC_STAGES  (SYNC_STAGES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .button       (button[i]),
      .level        (level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .press_d      (press_d[i])
    );
  end

  // Registered from the same next-state terms as press_pulse, so it lines
  // up with them cycle-for-cycle without a combinational OR on the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_press <= 1'b0;
    else        any_press <= |press_d;
  end
endmodule

// File: tb/tb_debounce_multi.sv
module tb_debounce_multi;
  localparam int HOLD = 4;
  localparam int SYNC = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] button = 2'b00;
  logic [1:0] lvl0, pp0, rp0, lvl1, pp1, rp1;
  logic       any0, any1;

  always #5 clk = ~clk;

  debounce_multi #(.N_CH(2), .HOLD_CYCLES(HOLD), .SYNC_STAGES(SYNC), .REPEAT_CYCLES(0)) dut (
    .clk(clk), .rst_n(rst_n), .button(button),
    .level(lvl0), .press_pulse(pp0), .release_pulse(rp0), .any_press(any0));

  debounce_multi #(.N_CH(2), .HOLD_CYCLES(HOLD), .SYNC_STAGES(SYNC), .REPEAT_CYCLES(8)) dut_rep (
    .clk(clk), .rst_n(rst_n), .button(button),
    .level(lvl1), .press_pulse(pp1), .release_pulse(rp1), .any_press(any1));

  int pass_cnt = 0;
  int tot = 0;

  // Reference model: a level flips once the last HOLD synchronised samples
  // all disagree with it; synchronised sample = button seen SYNC edges ago.
  logic [1:0] bq[$];
  logic [1:0] sh[$];
  logic [1:0] mlvl, mpp, mrp;

  function automatic void model_reset();
    bq.delete();
    sh.delete();
    for (int i = 0; i < SYNC; i++) bq.push_back(2'b00);
    for (int i = 0; i < HOLD; i++) sh.push_back(2'b00);
    mlvl = 2'b00; mpp = 2'b00; mrp = 2'b00;
  endfunction

  function automatic void model_edge(input logic [1:0] b);
    logic [1:0] s;
    bit all;
    bq.push_back(b);
    s = bq[0];
    void'(bq.pop_front());
    sh.push_back(s);
    if (sh.size() > HOLD) void'(sh.pop_front());
    mpp = 2'b00; mrp = 2'b00;
    for (int c = 0; c < 2; c++) begin
      all = 1'b1;
      foreach (sh[j]) if (sh[j][c] == mlvl[c]) all = 1'b0;
      if (all) begin
        mlvl[c] = ~mlvl[c];
        if (mlvl[c]) mpp[c] = 1'b1; else mrp[c] = 1'b1;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst_n) model_reset();
    else        model_edge(button);
    chk("model", {25'd0, lvl0, pp0, rp0, any0}, {25'd0, mlvl, mpp, mrp, |mpp});
  endtask

  typedef struct {
    logic [1:0] btn;
    logic [1:0] lvl;
    logic [1:0] pp;
    logic [1:0] rp;
  } vec_t;
  vec_t tv[34];

  int rep_k[$];
  int rel_k;
  int any_n, any_k;
  logic [1:0] any_pp;
  int per;

  initial begin
    // hand-derived per-cycle vectors: press, release, bounce on ch0
    for (int i = 0; i < 34; i++) tv[i] = '{btn: 2'b00, lvl: 2'b00, pp: 2'b00, rp: 2'b00};
    for (int i = 0; i < 10; i++) tv[i].btn = 2'b01;
    for (int i = 5; i < 15; i++) tv[i].lvl = 2'b01;
    tv[5].pp  = 2'b01;
    tv[15].rp = 2'b01;
    for (int i = 20; i < 23; i++) tv[i].btn = 2'b01;
    for (int i = 24; i < 27; i++) tv[i].btn = 2'b01;

    // reset with buttons pressed
    model_reset();
    button = 2'b11;
    rst_n  = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {24'd0, lvl0, pp0, rp0, any0, any1}, 32'd0);
    chk("reset_outputs_rep", {26'd0, lvl1, pp1, rp1}, 32'd0);

    button = 2'b00;
    rst_n  = 1'b1;
    for (int i = 0; i < 34; i++) begin
      button = tv[i].btn;
      tick();
      chk($sformatf("vec%0d", i), {26'd0, lvl0, pp0, rp0}, {26'd0, tv[i].lvl, tv[i].pp, tv[i].rp});
    end

    // auto-repeat on ch1: accept at 5, repeats every 8 while held
    rel_k = -1;
    for (int k = 0; k < 40; k++) begin
      button = (k < 30) ? 2'b10 : 2'b00;
      tick();
      if (pp1[1]) rep_k.push_back(k);
      if (rp1[1]) rel_k = k;
      chk("rep_ch0_quiet", {30'd0, pp1[0], rp1[0]}, 32'd0);
    end
    chk("rep_count", rep_k.size(), 4);
    for (int j = 0; j < 4 && j < rep_k.size(); j++) chk($sformatf("rep_at%0d", j), rep_k[j], 5 + 8 * j);
    chk("rep_release_at", rel_k, 35);

    // reset mid-hold, then re-acceptance of both held buttons
    button = 2'b11;
    repeat (10) tick();
    chk("hold_level", {30'd0, lvl0}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {24'd0, lvl0, pp0, rp0, any0, lvl1[0]}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    any_n = 0; any_k = -1; any_pp = 2'b00;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (any0) begin any_n++; any_k = k; any_pp = pp0; end
    end
    chk("post_reset_any_count", any_n, 1);
    chk("post_reset_any_at", any_k, 6);
    chk("post_reset_both", {30'd0, any_pp}, 32'd3);

    // randomized phases with varying bounce rates and occasional resets
    button = 2'b00;
    repeat (8) tick();
    for (int blk = 0; blk < 15; blk++) begin
      per = (blk % 3 == 0) ? 2 : ((blk % 3 == 1) ? 7 : 25);
      for (int c = 0; c < 200; c++) begin
        for (int ch = 0; ch < 2; ch++)
          if ($urandom_range(per - 1) == 0) button[ch] = ~button[ch];
        if ($urandom_range(399) == 0) begin
          rst_n = 1'b0;
          tick();
          rst_n = 1'b1;
        end
        tick();
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, tot);
    $finish;
  end
endmodule
